// File: rtl/pic_pkg.sv
// Shared PIC definitions: ISR sequencing states, EOI modes and the NUM_IRQ legality check.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT2  = 2'd1,
        VECTOR = 2'd2
    } isr_state_e;

    typedef enum logic [1:0] {
        EOI_NONE    = 2'd0,
        EOI_NONSPEC = 2'd1,
        EOI_SPEC    = 2'd2,
        EOI_AUTO    = 2'd3
    } eoi_mode_e;

    localparam int unsigned MAX_IRQ = 64;

    function automatic bit num_irq_legal(input int unsigned n);
        return (n >= 2) && (n <= MAX_IRQ) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/isr_circular_scan.sv
// Find-first-set over the ISR, starting at base and wrapping modulo NUM_IRQ.
module isr_circular_scan #(
    parameter  int unsigned NUM_IRQ = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   base,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Index arithmetic is IDX_W wide, so the wrap comes for free.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!found && vec[base + IDX_W'(i)]) begin
                found = 1'b1;
                index = base + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/in_service_ctrl.sv
// In-service register for the PIC: INTA sequencing, vector emission, EOI clearing.
// Optional priority rotation is enabled with `define ISR_ROTATE_EN.
module in_service_ctrl
    import pic_pkg::*;
#(
    parameter  int unsigned NUM_IRQ = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               firstAck,
    input  logic               secondAck,
    input  logic               grantValid,
    input  logic [IDX_W-1:0]   grantIndex,
    input  logic [7:0]         vectorBase,
    input  logic               aeoiEn,
    input  logic               eoiValid,
    input  logic               eoiSpecific,
    input  logic [IDX_W-1:0]   eoiLevel,
    input  logic               eoiRotate,
    input  logic               readIsr,
    output logic [NUM_IRQ-1:0] isrValue,
    output logic [IDX_W-1:0]   priorityBase,
    output logic [7:0]         vectorOut,
    output logic               vectorValid,
    output logic [NUM_IRQ-1:0] isrData,
    output logic               eoiDone,
    output logic [IDX_W-1:0]   clearedIndex,
    output logic               eoiEmpty
);

    if (!num_irq_legal(NUM_IRQ)) begin : g_bad_num_irq
        $error("in_service_ctrl: NUM_IRQ must be a power of two in 2..64");
    end

    isr_state_e         r_state;
    logic [NUM_IRQ-1:0] r_isr;
    logic [IDX_W-1:0]   r_cur_idx;
    logic               r_spurious;
    logic [7:0]         r_vector_out;
    logic               r_vector_valid;
    logic [NUM_IRQ-1:0] r_isr_data;
    logic               r_eoi_done;
    logic               r_eoi_empty;
    logic [IDX_W-1:0]   r_cleared_idx;

    logic [IDX_W-1:0]   w_priority_base;
    logic               w_scan_found;
    logic [IDX_W-1:0]   w_scan_idx;
    eoi_mode_e          w_eoi_mode;
    logic [IDX_W-1:0]   w_clr_idx;
    logic               w_clr_found;
    logic               w_set;
    logic [NUM_IRQ-1:0] w_isr_next;
    logic [IDX_W-1:0]   w_unused_vbase;

    assign w_unused_vbase = vectorBase[IDX_W-1:0];

    isr_circular_scan #(.NUM_IRQ(NUM_IRQ)) u_scan (
        .vec   (r_isr),
        .base  (w_priority_base),
        .found (w_scan_found),
        .index (w_scan_idx)
    );

    // AEOI in the VECTOR cycle takes precedence over a command EOI.
    always_comb begin
        w_eoi_mode = EOI_NONE;
        w_clr_idx  = '0;
        if (r_state == VECTOR && aeoiEn && !r_spurious) begin
            w_eoi_mode = EOI_AUTO;
            w_clr_idx  = r_cur_idx;
        end else if (eoiValid) begin
            w_eoi_mode = eoiSpecific ? EOI_SPEC : EOI_NONSPEC;
            w_clr_idx  = eoiSpecific ? eoiLevel : w_scan_idx;
        end
    end

    always_comb begin
        w_clr_found = 1'b0;
        case (w_eoi_mode)
            EOI_NONSPEC: w_clr_found = w_scan_found;
            EOI_SPEC,
            EOI_AUTO:    w_clr_found = r_isr[w_clr_idx];
            default:     w_clr_found = 1'b0;
        endcase
    end

    // Clear first, then set, so a grant on the same level survives.
    assign w_set = (r_state == IDLE) && firstAck && grantValid;

    always_comb begin
        w_isr_next = r_isr;
        if (w_clr_found) w_isr_next[w_clr_idx] = 1'b0;
        if (w_set)       w_isr_next[grantIndex] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_isr          <= '0;
            r_cur_idx      <= '0;
            r_spurious     <= 1'b0;
            r_vector_out   <= '0;
            r_vector_valid <= 1'b0;
            r_isr_data     <= '0;
            r_eoi_done     <= 1'b0;
            r_eoi_empty    <= 1'b0;
            r_cleared_idx  <= '0;
        end else begin
            r_isr          <= w_isr_next;
            r_vector_valid <= 1'b0;
            r_eoi_done     <= w_clr_found;
            r_eoi_empty    <= (w_eoi_mode != EOI_NONE) && !w_clr_found;
            if (w_clr_found) r_cleared_idx <= w_clr_idx;
            if (readIsr)     r_isr_data    <= r_isr;
            case (r_state)
                IDLE: begin
                    if (firstAck) begin
                        r_state    <= WAIT2;
                        r_spurious <= !grantValid;
                        r_cur_idx  <= grantValid ? grantIndex : IDX_W'(NUM_IRQ - 1);
                    end
                end
                WAIT2: begin
                    if (secondAck) begin
                        r_state        <= VECTOR;
                        r_vector_valid <= 1'b1;
                        r_vector_out   <= {vectorBase[7:IDX_W], r_cur_idx};
                    end
                end
                VECTOR:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ISR_ROTATE_EN
    logic [IDX_W-1:0] r_priority_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_priority_base <= '0;
        end else if (w_clr_found && eoiRotate) begin
            r_priority_base <= w_clr_idx + IDX_W'(1);
        end
    end

    assign w_priority_base = r_priority_base;
`else
    logic w_unused_rotate;

    assign w_unused_rotate = eoiRotate;
    assign w_priority_base = '0;
`endif

    assign isrValue     = r_isr;
    assign priorityBase = w_priority_base;
    assign vectorOut    = r_vector_out;
    assign vectorValid  = r_vector_valid;
    assign isrData      = r_isr_data;
    assign eoiDone      = r_eoi_done;
    assign clearedIndex = r_cleared_idx;
    assign eoiEmpty     = r_eoi_empty;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Scoreboard bench for in_service_ctrl (NUM_IRQ=8); follows ISR_ROTATE_EN like the DUT.
module tb_in_service_ctrl;

`ifdef ISR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam int EV_VEC   = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_EMPTY = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       firstAck, secondAck, grantValid, aeoiEn;
    logic [2:0] grantIndex, eoiLevel;
    logic [7:0] vectorBase;
    logic       eoiValid, eoiSpecific, eoiRotate, readIsr;
    logic [7:0] isrValue, vectorOut, isrData;
    logic [2:0] priorityBase, clearedIndex;
    logic       vectorValid, eoiDone, eoiEmpty;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] exp_last = 3'd0;

    in_service_ctrl #(.NUM_IRQ(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .firstAck     (firstAck),
        .secondAck    (secondAck),
        .grantValid   (grantValid),
        .grantIndex   (grantIndex),
        .vectorBase   (vectorBase),
        .aeoiEn       (aeoiEn),
        .eoiValid     (eoiValid),
        .eoiSpecific  (eoiSpecific),
        .eoiLevel     (eoiLevel),
        .eoiRotate    (eoiRotate),
        .readIsr      (readIsr),
        .isrValue     (isrValue),
        .priorityBase (priorityBase),
        .vectorOut    (vectorOut),
        .vectorValid  (vectorValid),
        .isrData      (isrData),
        .eoiDone      (eoiDone),
        .clearedIndex (clearedIndex),
        .eoiEmpty     (eoiEmpty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [7:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: kind %0d value 0x%0h with nothing expected", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_value", 32'(val), 32'(e.val));
        end
    endtask

    // Monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (vectorValid === 1'b1) check_ev(EV_VEC, vectorOut);
        if (eoiDone === 1'b1)     check_ev(EV_DONE, 8'(clearedIndex));
        if (eoiEmpty === 1'b1)    check_ev(EV_EMPTY, 8'(clearedIndex));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack1(input logic valid, input logic [2:0] idx);
        grantValid = valid;
        grantIndex = idx;
        firstAck   = 1'b1;
        tick();
        firstAck   = 1'b0;
        grantValid = 1'b0;
    endtask

    task automatic ack2(input logic [7:0] exp_vec);
        push(EV_VEC, exp_vec);
        secondAck = 1'b1;
        tick();
        secondAck = 1'b0;
    endtask

    task automatic inta(input logic valid, input logic [2:0] idx, input logic [7:0] exp_vec);
        ack1(valid, idx);
        ack2(exp_vec);
        tick();
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
        eoiValid    = 1'b1;
        eoiSpecific = spec;
        eoiLevel    = lvl;
        eoiRotate   = rot;
        tick();
        eoiValid    = 1'b0;
        eoiRotate   = 1'b0;
    endtask

    task automatic chk_all_zero();
        chk("rst_isrValue", 32'(isrValue), 32'h0);
        chk("rst_priorityBase", 32'(priorityBase), 32'h0);
        chk("rst_vectorOut", 32'(vectorOut), 32'h0);
        chk("rst_vectorValid", 32'(vectorValid), 32'h0);
        chk("rst_isrData", 32'(isrData), 32'h0);
        chk("rst_eoiDone", 32'(eoiDone), 32'h0);
        chk("rst_clearedIndex", 32'(clearedIndex), 32'h0);
        chk("rst_eoiEmpty", 32'(eoiEmpty), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; firstAck = 1'b0; secondAck = 1'b0; grantValid = 1'b0;
        grantIndex = 3'd0; vectorBase = 8'h40; aeoiEn = 1'b0; eoiValid = 1'b0;
        eoiSpecific = 1'b0; eoiLevel = 3'd0; eoiRotate = 1'b0; readIsr = 1'b0;
        repeat (3) tick();
        chk_all_zero();
        rst_n = 1'b1;
        tick();

        // Level 2 in service, then specific EOI with rotation request.
        ack1(1'b1, 3'd2);
        chk("set_bit2", 32'(isrValue), 32'h04);
        ack2(8'h42);
        tick();
        push(EV_DONE, 8'd2);
        eoi(1'b1, 3'd2, 1'b1);
        exp_last = 3'd2;
        chk("spec_eoi_isr", 32'(isrValue), 32'h00);
        chk("spec_eoi_base", 32'(priorityBase), ROT ? 32'd3 : 32'd0);

        // Level 5, with a stray firstAck in WAIT2 that must be ignored.
        ack1(1'b1, 3'd5);
        chk("set_bit5", 32'(isrValue), 32'h20);
        ack1(1'b1, 3'd6);
        chk("wait2_firstack_ignored", 32'(isrValue), 32'h20);
        ack2(8'h45);
        tick();
        chk("vector_hold", 32'(vectorOut), 32'h45);

        // Spurious acknowledge.
        inta(1'b0, 3'd0, 8'h47);
        chk("spurious_isr", 32'(isrValue), 32'h20);

        inta(1'b1, 3'd2, 8'h42);
        chk("isr_0x24", 32'(isrValue), 32'h24);
        readIsr = 1'b1;
        tick();
        readIsr = 1'b0;
        chk("read_isr", 32'(isrData), 32'h24);

        // Non-specific EOIs: from base 3 (rotating) or base 0 (fixed).
        push(EV_DONE, ROT ? 8'd5 : 8'd2);
        eoi(1'b0, 3'd0, 1'b1);
        chk("nonspec1_isr", 32'(isrValue), ROT ? 32'h04 : 32'h20);
        chk("nonspec1_base", 32'(priorityBase), ROT ? 32'd6 : 32'd0);
        push(EV_DONE, ROT ? 8'd2 : 8'd5);
        eoi(1'b0, 3'd0, 1'b0);
        exp_last = ROT ? 3'd2 : 3'd5;
        chk("nonspec2_isr", 32'(isrValue), 32'h00);
        chk("nonspec2_base", 32'(priorityBase), ROT ? 32'd6 : 32'd0);

        // EOIs that find nothing.
        push(EV_EMPTY, 8'(exp_last));
        eoi(1'b0, 3'd0, 1'b0);
        push(EV_EMPTY, 8'(exp_last));
        eoi(1'b1, 3'd7, 1'b0);
        chk("empty_isr", 32'(isrValue), 32'h00);

        // Automatic EOI.
        aeoiEn = 1'b1;
        ack1(1'b1, 3'd2);
        chk("aeoi_set", 32'(isrValue), 32'h04);
        push(EV_VEC, 8'h42);
        push(EV_DONE, 8'd2);
        secondAck = 1'b1;
        tick();
        secondAck = 1'b0;
        tick();
        chk("aeoi_cleared", 32'(isrValue), 32'h00);
        aeoiEn = 1'b0;
        tick();

        // Set and specific clear of the same level in one cycle.
        inta(1'b1, 3'd3, 8'h43);
        chk("isr_0x08", 32'(isrValue), 32'h08);
        push(EV_DONE, 8'd3);
        eoiValid = 1'b1; eoiSpecific = 1'b1; eoiLevel = 3'd3;
        ack1(1'b1, 3'd3);
        eoiValid = 1'b0;
        chk("set_wins", 32'(isrValue), 32'h08);
        ack2(8'h43);
        tick();
        push(EV_DONE, 8'd3);
        eoi(1'b1, 3'd3, 1'b0);
        chk("clear_3", 32'(isrValue), 32'h00);

        // AEOI and command EOI collide: command dropped.
        inta(1'b1, 3'd4, 8'h44);
        aeoiEn = 1'b1;
        ack1(1'b1, 3'd1);
        chk("isr_0x12", 32'(isrValue), 32'h12);
        push(EV_VEC, 8'h41);
        push(EV_DONE, 8'd1);
        secondAck = 1'b1;
        tick();
        secondAck = 1'b0;
        eoiValid = 1'b1; eoiSpecific = 1'b0;
        tick();
        eoiValid = 1'b0;
        aeoiEn = 1'b0;
        chk("collision_isr", 32'(isrValue), 32'h10);
        push(EV_DONE, 8'd4);
        eoi(1'b1, 3'd4, 1'b0);
        chk("clear_4", 32'(isrValue), 32'h00);

        // Reset during WAIT2: no vector, everything back to zero.
        ack1(1'b1, 3'd6);
        chk("set_bit6", 32'(isrValue), 32'h40);
        rst_n = 1'b0;
        tick();
        chk_all_zero();
        rst_n = 1'b1;
        tick();
        secondAck = 1'b1;
        tick();
        secondAck = 1'b0;
        repeat (3) tick();
        chk("post_reset_isr", 32'(isrValue), 32'h00);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/in_service_ctrl.md
# in_service_ctrl

Clocked, parametrised in-service register (ISR) for the PIC. It records which interrupt level is being serviced across the two-pulse INTA sequence and emits the interrupt vector. It clears levels on automatic, non-specific or specific EOI, and supports optional priority rotation. It sits between the priority resolver, which consumes `isrValue` and `priorityBase`, and the data-bus buffer, which consumes `vectorOut` and `isrData`.

## Interface
- `NUM_IRQ`, 8: number of interrupt levels; power of two, 2..64.
- `IDX_W`, $clog2(NUM_IRQ): level index width; derived, never overridden.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `firstAck`  in  1  one-cycle pulse, first INTA.
- `secondAck`  in  1  one-cycle pulse, second INTA.
- `grantValid`  in  1  resolver has a winning request.
- `grantIndex`  in  IDX_W  winning level.
- `vectorBase`  in  8  ICW2; the upper `8-IDX_W` bits are used.
- `aeoiEn`  in  1  automatic-EOI mode (ICW4.AEOI).
- `eoiValid`  in  1  one-cycle EOI command strobe from the OCW2 decode.
- `eoiSpecific`  in  1  1 = specific EOI, 0 = non-specific.
- `eoiLevel`  in  IDX_W  level for specific EOI.
- `eoiRotate`  in  1  rotate priority on this EOI (also applies in AEOI).
- `readIsr`  in  1  capture the ISR onto `isrData`.
- `isrValue`  out  NUM_IRQ  current ISR; reset 0.
- `priorityBase`  out  IDX_W  highest-priority level; reset 0.
- `vectorOut`  out  8  vector byte; reset 0.
- `vectorValid`  out  1  one-cycle vector strobe; reset 0.
- `isrData`  out  NUM_IRQ  snapshot of the ISR; reset 0.
- `eoiDone`  out  1  one-cycle pulse, a bit was cleared; reset 0.
- `clearedIndex`  out  IDX_W  level cleared by the last EOI; reset 0.
- `eoiEmpty`  out  1  one-cycle pulse, an EOI found nothing to clear; reset 0.

## Operation
- FSM states: IDLE, WAIT2, VECTOR.
- IDLE: on `firstAck`:
  - if `grantValid`, set `isr[grantIndex]` and latch `curIdx = grantIndex`;
  - else treat as spurious: latch `curIdx = NUM_IRQ-1`, set no bit.
  - Next state WAIT2.
- WAIT2: on `secondAck` go to VECTOR. A `firstAck` seen in WAIT2 is ignored.
- VECTOR (one cycle):
  - `vectorOut = {vectorBase[7:IDX_W], curIdx}`; `vectorValid = 1`.
  - If `aeoiEn` and not spurious, clear `isr[curIdx]` as a specific EOI.
  - Return to IDLE.
- `secondAck` received in IDLE is ignored.
- Non-specific EOI: circular scan from `priorityBase` upward, wrapping modulo NUM_IRQ. The first set bit is cleared.
- Specific EOI: clear `isr[eoiLevel]`.
- Every EOI (command or AEOI):
  - bit found and cleared: `eoiDone` pulses and `clearedIndex` updates;
  - no bit found (empty ISR, or specific level not set): `eoiEmpty` pulses instead; ISR and `clearedIndex` are unchanged.
- Rotation: when a bit is cleared and `eoiRotate` = 1, `priorityBase` becomes `(clearedIndex+1) mod NUM_IRQ`.
- Simultaneous set and clear in the same cycle:
  - the EOI scan uses the ISR value from before that edge;
  - the set is applied after the clear, so set wins on the same bit.
- An AEOI clear and an `eoiValid` clear in the same cycle: AEOI is applied and the command is dropped; `eoiEmpty` does not pulse.
- `readIsr`: `isrData` takes the pre-edge ISR.

## Timing
- ISR bit visible on `isrValue` 1 cycle after the `firstAck` edge.
- `vectorValid` asserts in the cycle after `secondAck`, for exactly 1 cycle. `vectorOut` holds its value until the next vector.
- EOI command to updated `isrValue`, `eoiDone` and `priorityBase`: 1 cycle.
- `isrData` is valid 1 cycle after `readIsr`.
- Reset mid-sequence: FSM returns to IDLE; ISR and all outputs go to their reset values. The pending vector is not emitted.

## Configuration
- `ISR_ROTATE_EN` defined: `eoiRotate` is honoured and `priorityBase` is a register.
- Not defined: `eoiRotate` is ignored and `priorityBase` is constant 0, giving fixed priority with level 0 highest.

## Structure
- Shared package `pic_pkg` holds:
  - the FSM state enum (IDLE/WAIT2/VECTOR);
  - the EOI mode constants;
  - the NUM_IRQ legality check: power of two, ≤64.
- Sub-module `isr_circular_scan`: combinational find-first-set starting at a base index with wrap. Outputs `found` and `index`.

## Test plan
- NUM_IRQ=8, grantIndex=5, vectorBase=0x40, `firstAck` then `secondAck` → `isrValue`=0x20; `vectorOut`=0x45 with a 1-cycle `vectorValid`.
- Spurious: `firstAck` with `grantValid`=0, vectorBase=0x40 → ISR stays 0; `vectorOut`=0x47.
- ISR=0x24, priorityBase=3, non-specific EOI → bit 5 cleared, `clearedIndex`=5, `eoiDone`. With `eoiRotate`=1 → `priorityBase`=6.
- aeoiEn=1, grant 2 → ISR never retains bit 2 after VECTOR; `eoiDone` pulses with `clearedIndex`=2.
- Specific EOI for level 3 in the same cycle as `firstAck` granting 3, ISR=0x08 → ISR stays 0x08 (set wins); `eoiDone` pulses.
- Empty ISR with non-specific EOI → `eoiEmpty` pulses, `clearedIndex` unchanged. `rst_n`=0 during WAIT2 → no `vectorValid`, and all outputs are 0.
